// File: rtl/rk_mem_arbiter_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
// Imported by the arbiter top and its slot timer.
package rk_mem_arbiter_pkg;

    localparam int MEM_AW = 18;
    localparam int MEM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLOT_V = 2'd1,
        ST_SLOT_C = 2'd2
    } arb_state_e;

    function automatic logic cpu_wins(input logic cpu_req,
                                      input logic vid_req,
                                      input logic prio);
        return cpu_req & (~vid_req | prio);
    endfunction

endpackage

// File: rtl/rk_slot_timer.sv
// Loadable slot counter with end-of-slot and read-sample strobes.
// Holds at SLOT_LEN-1 instead of wrapping.
module rk_slot_timer
    import rk_mem_arbiter_pkg::*;
#(
    parameter int SLOT_LEN = 8,
    parameter int RD_LAT   = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic done_o,
    output logic sample_o
);

    localparam int CW = $clog2(SLOT_LEN);
    localparam logic [CW-1:0] LAST = CW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] SAMP = CW'(RD_LAT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && !done_o)
            cnt_d = cnt_q + 1'b1;
    end

    assign done_o   = (cnt_q == LAST);
    assign sample_o = (cnt_q == SAMP);

endmodule

// File: rtl/rk_mem_arbiter.sv
// Fixed-slot arbiter sharing one SDRAM controller port between
// the video DMA read path and the CPU read/write path.
module rk_mem_arbiter
    import rk_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int SLOT_LEN = 8,
    parameter int RD_LAT   = 6
) (
    input  logic                clk50mhz,
    input  logic                reset,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic [MEM_DW-1:0]   vid_rdata,
    output logic                vid_ack,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [MEM_DW-1:0]   cpu_wdata,
    output logic [MEM_DW-1:0]   cpu_rdata,
    output logic                cpu_ack,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [MEM_DW-1:0]   mem_wdata,
    output logic                mem_rd,
    output logic                mem_we_n,
    input  logic [15:0]         mem_rdata,
    output logic                busy
);

    arb_state_e        state_q, state_d;
    logic              prio_q, prio_d;
    logic              wr_q, wr_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [MEM_DW-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              we_n_q, we_n_d;
    logic [MEM_DW-1:0] vrd_q, vrd_d;
    logic [MEM_DW-1:0] crd_q, crd_d;
    logic              vack_q, vack_d;
    logic              cack_q, cack_d;
    logic              busy_q, busy_d;
    logic              load, done, sample;
    logic              unused_hi;

    assign unused_hi = ^mem_rdata[15:8];

    rk_slot_timer #(
        .SLOT_LEN (SLOT_LEN),
        .RD_LAT   (RD_LAT)
    ) u_timer (
        .clk_i    (clk50mhz),
        .rst_i    (reset),
        .load_i   (load),
        .en_i     (state_q != ST_IDLE),
        .done_o   (done),
        .sample_o (sample)
    );

    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            we_n_q  <= 1'b1;
            vrd_q   <= '0;
            crd_q   <= '0;
            vack_q  <= 1'b0;
            cack_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            we_n_q  <= we_n_d;
            vrd_q   <= vrd_d;
            crd_q   <= crd_d;
            vack_q  <= vack_d;
            cack_q  <= cack_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        we_n_d  = we_n_q;
        vrd_d   = vrd_q;
        crd_d   = crd_q;
        vack_d  = 1'b0;
        cack_d  = 1'b0;
        busy_d  = busy_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rd_d   = 1'b0;
                we_n_d = 1'b1;
                busy_d = 1'b0;
                if (cpu_wins(cpu_req, vid_req, prio_q)) begin
                    state_d = ST_SLOT_C;
                    prio_d  = 1'b0;
                    wr_d    = cpu_we;
                    addr_d  = MEM_AW'(cpu_addr);
                    wdata_d = cpu_wdata;
                    rd_d    = ~cpu_we;
                    we_n_d  = ~cpu_we;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end else if (vid_req) begin
                    state_d = ST_SLOT_V;
                    prio_d  = prio_q | cpu_req;
                    wr_d    = 1'b0;
                    addr_d  = MEM_AW'(vid_addr);
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_SLOT_V, ST_SLOT_C: begin
                if (sample && !wr_q) begin
                    if (state_q == ST_SLOT_V) vrd_d = mem_rdata[7:0];
                    else                      crd_d = mem_rdata[7:0];
                end
                // Ack only if the requester is still waiting at slot end
                if (done) begin
                    state_d = ST_IDLE;
                    rd_d    = 1'b0;
                    we_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    vack_d  = (state_q == ST_SLOT_V) & vid_req;
                    cack_d  = (state_q == ST_SLOT_C) & cpu_req;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                we_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign vid_rdata = vrd_q;
    assign vid_ack   = vack_q;
    assign cpu_rdata = crd_q;
    assign cpu_ack   = cack_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = rd_q;
    assign mem_we_n  = we_n_q;
    assign busy      = busy_q;

endmodule
